matrix_keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces it, and encodes the held key as the 5-bit key code with a one-cycle acceptance pulse. It is the producer end of the keypad interface: its `keyvalue`/`keyfinish` outputs feed the game controller directly.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_debounce.sv | 84 ++++++++
 rtl/matrix_keypad_scanner.sv | 113 +++++++++++
 tb/tb_matrix_keypad_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and scan FSM state type for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [4:0] NO_KEY = 5'b10000;

    localparam logic [1:0] ST_DRIVE  = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_EVAL   = 2'd2;

    typedef enum logic [1:0] {
        DRIVE  = ST_DRIVE,
        SAMPLE = ST_SAMPLE,
        EVAL   = ST_EVAL
    } scan_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Debounces per-round scan results into keyvalue/keyfinish.
// Optional auto-repeat of keyfinish is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 10,
    parameter int REPEAT_ROUNDS  = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic [4:0] result,
    output logic [4:0] keyvalue,
    output logic       keyfinish
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    if (DEBOUNCE_SCANS < 1 || REPEAT_ROUNDS < 1) begin : g_param_check
        $error("DEBOUNCE_SCANS and REPEAT_ROUNDS must be >= 1");
    end

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [4:0]    prev;
    logic          accept;
    logic          repeat_pulse;

    always_comb begin
        if (result == prev) begin
            count_next = (count == CW'(DEBOUNCE_SCANS)) ? count : count + CW'(1);
        end else begin
            count_next = CW'(1);
        end
        accept = strobe && (count_next == CW'(DEBOUNCE_SCANS)) && (result != keyvalue);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_ROUNDS + 1);

    logic [RW-1:0] rep_count;

    // Fires on the EVAL that would bring the count to REPEAT_ROUNDS.
    always_comb begin
        repeat_pulse = strobe && !accept && (keyvalue != NO_KEY)
                       && (rep_count == RW'(REPEAT_ROUNDS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_count <= '0;
        end else if (strobe) begin
            if (accept || repeat_pulse) begin
                rep_count <= '0;
            end else if (keyvalue != NO_KEY) begin
                rep_count <= rep_count + RW'(1);
            end
        end
    end
`else
    always_comb begin
        repeat_pulse = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            prev      <= NO_KEY;
            keyvalue  <= NO_KEY;
            keyfinish <= 1'b0;
        end else begin
            keyfinish <= (accept && (result != NO_KEY)) || repeat_pulse;
            if (strobe) begin
                count <= count_next;
                prev  <= result;
            end
            if (accept) begin
                keyvalue <= result;
            end
        end
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: row synchroniser, column scan FSM, round accumulation.
// Define KEYPAD_REPEAT_EN to enable keyfinish auto-repeat in keypad_debounce.
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int REPEAT_ROUNDS  = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] keyvalue,
    output logic       keyfinish
);

    localparam int DW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4) begin : g_param_check
        $error("SCAN_DIV must be >= 4");
    end

    scan_state_t state;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [1:0]    hits;
    logic [3:0]    hit_code;

    logic [2:0]    low_cnt;
    logic [1:0]    low_row;
    logic [2:0]    hit_sum;
    logic [1:0]    hits_next;
    logic [3:0]    code_next;
    logic [4:0]    result;
    logic          strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // hits saturates at 2: any second low bit in the round means reject.
    always_comb begin
        low_cnt = '0;
        low_row = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync[r]) begin
                low_cnt = low_cnt + 3'd1;
                low_row = r[1:0];
            end
        end
        hit_sum   = {1'b0, (col_idx == 2'd0) ? 2'd0 : hits} + low_cnt;
        hits_next = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
        code_next = (low_cnt == 3'd1) ? {low_row, col_idx} : hit_code;
        result    = (hits == 2'd1) ? {1'b0, hit_code} : NO_KEY;
        strobe    = (state == EVAL);
        col       = ~(4'b0001 << col_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DRIVE;
            div      <= '0;
            col_idx  <= '0;
            hits     <= '0;
            hit_code <= '0;
        end else begin
            case (state)
                DRIVE: begin
                    if (div == DW'(SCAN_DIV - 2)) begin
                        state <= SAMPLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                SAMPLE: begin
                    hits     <= hits_next;
                    hit_code <= code_next;
                    div      <= '0;
                    col_idx  <= col_idx + 2'd1;
                    state    <= (col_idx == 2'd3) ? EVAL : DRIVE;
                end
                EVAL: begin
                    state <= DRIVE;
                end
                default: begin
                    state <= DRIVE;
                end
            endcase
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_ROUNDS (REPEAT_ROUNDS)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe   (strobe),
        .result   (result),
        .keyvalue (keyvalue),
        .keyfinish(keyfinish)
    );

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Self-checking bench for matrix_keypad_scanner with a round-level keypad model.
// Honours KEYPAD_REPEAT_EN for the auto-repeat expectation.
module tb_matrix_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;
    localparam int ROUND    = 4 * SCAN_DIV + 1;
    localparam int NOKEY    = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] keyvalue;
    logic       keyfinish;

    logic [15:0] pressed;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int t        = 0;
    int p0;

    // model state
    int          hist[$];
    int          exp_kv;
    int          exp_kf;
    int          rep;
    logic [15:0] cur_mask;

    matrix_keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_ROUNDS (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .keyvalue (keyvalue),
        .keyfinish(keyfinish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key (r,c) shorts row r to column c; code r*4+c is bit index of pressed.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[4*r +: 4] & ~col);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, t=%0d", t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_kv   = NOKEY;
        exp_kf   = 0;
        rep      = 0;
        cur_mask = '0;
        t        = 0;
    endtask

    // Round-level model: result of a round is the single pressed key or NOKEY.
    task automatic model_step();
        int  res;
        int  v;
        bit  stable;
        exp_kf = 0;
        if (t % ROUND == 8) cur_mask = pressed;
        if (t > 0 && t % ROUND == 0) begin
            res = NOKEY;
            if ($countones(cur_mask) == 1) begin
                for (int i = 0; i < 16; i++) if (cur_mask[i]) res = i;
            end
            hist.push_back(res);
            if (hist.size() > DEB) void'(hist.pop_front());
            stable = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] != res) stable = 0;
            if (stable && res != exp_kv) begin
                exp_kv = res;
                exp_kf = (res != NOKEY) ? 1 : 0;
                rep    = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
                if (exp_kv != NOKEY) begin
                    rep++;
                    if (rep == REP) begin
                        exp_kf = 1;
                        rep    = 0;
                    end
                end
`endif
            end
        end
        v = t % ROUND;
        chk("col", int'(col), int'(~(4'b0001 << ((v == ROUND - 1) ? 0 : v / SCAN_DIV)) & 4'hF));
        chk("keyvalue", int'(keyvalue), exp_kv);
        chk("keyfinish", int'(keyfinish), exp_kf);
    endtask

    // Entered and left at posedge+#1; t counts posedges since reset release.
    task automatic cycle();
        @(negedge clk);
        model_step();
        if (keyfinish) pulses++;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic rounds(input logic [15:0] m, input int k);
        repeat (k) begin
            pressed = m;
            repeat (ROUND) cycle();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pressed = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_col", int'(col), 4'b1110);
        chk("reset_keyvalue", int'(keyvalue), 16);
        chk("reset_keyfinish", int'(keyfinish), 0);
        rst_n = 1'b1;

        p0 = pulses;
        rounds(16'h0000, 2);
        chk("idle_keyvalue", int'(keyvalue), 16);
        chk("idle_pulses", pulses - p0, 0);

        p0 = pulses;
        rounds(16'h0001 << 9, 4);
        chk("press9_keyvalue", int'(keyvalue), 9);
        chk("press9_pulses", pulses - p0, 1);

        p0 = pulses;
        rounds(16'h0000, 4);
        chk("release_keyvalue", int'(keyvalue), 16);
        chk("release_pulses", pulses - p0, 0);

        p0 = pulses;
        rounds(16'h0001, 1);
        rounds(16'h0000, 1);
        rounds(16'h0001, 2);
        chk("bounce_mid_keyvalue", int'(keyvalue), 16);
        chk("bounce_mid_pulses", pulses - p0, 0);
        rounds(16'h0001, 2);
        chk("bounce_keyvalue", int'(keyvalue), 0);
        chk("bounce_pulses", pulses - p0, 1);
        rounds(16'h0000, 4);

        p0 = pulses;
        rounds((16'h0001 << 3) | (16'h0001 << 12), 5);
        chk("multi_keyvalue", int'(keyvalue), 16);
        chk("multi_pulses", pulses - p0, 0);

        p0 = pulses;
        rounds(16'h0001 << 5, 4);
        chk("k2k_first_keyvalue", int'(keyvalue), 5);
        rounds(16'h0001 << 15, 4);
        chk("k2k_keyvalue", int'(keyvalue), 15);
        chk("k2k_pulses", pulses - p0, 2);

        repeat (7) cycle();
        rst_n = 1'b0;
        #1;
        chk("midreset_col", int'(col), 4'b1110);
        chk("midreset_keyvalue", int'(keyvalue), 16);
        chk("midreset_keyfinish", int'(keyfinish), 0);
        repeat (2) @(posedge clk);
        #1;
        pressed = '0;
        model_reset();
        rst_n = 1'b1;

        p0 = pulses;
        rounds(16'h0001 << 7, 20);
        chk("repeat_keyvalue", int'(keyvalue), 7);
`ifdef KEYPAD_REPEAT_EN
        chk("repeat_pulses", pulses - p0, 4);
`else
        chk("repeat_pulses", pulses - p0, 1);
`endif
        rounds(16'h0000, 4);
        chk("final_keyvalue", int'(keyvalue), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
